// File: rtl/telemetry_tx.sv
// Buffered serial telemetry transmitter: 8-entry sample FIFO feeding an
// 11-bit frame (start, 8 data LSB first, even parity, stop) on a registered tx line.
module telemetry_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       overflow
);

  // state  | meaning
  // IDLE   | line high, waiting for a buffered sample
  // START  | start bit (low)
  // DATA   | eight data bits, LSB first
  // PARITY | even parity over the data byte
  // STOP   | stop bit (high); pops the next sample at its end if one is waiting
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] BIT_LOAD = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DEPTH    = 4'(FIFO_DEPTH);

  state_t     state, state_next;
  logic [7:0] mem [FIFO_DEPTH];
  logic [2:0] wr_ptr, rd_ptr;
  logic [7:0] bit_cnt;
  logic [2:0] bit_idx, bit_idx_next;
  logic [7:0] frame_data, data_next;
  logic       bit_tc, push, pop, tx_next;

  assign sample_ready = (fifo_count < DEPTH);
  assign push         = sample_valid & sample_ready;
  assign bit_tc       = (bit_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_count != 4'd0) state_next = START;
      START:   if (bit_tc) state_next = DATA;
      DATA:    if (bit_tc && bit_idx == 3'd7) state_next = PARITY;
      PARITY:  if (bit_tc) state_next = STOP;
      STOP:    if (bit_tc) state_next = (fifo_count != 4'd0) ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is computed from the upcoming state so the registered line lines up with it
  always_comb begin
    busy         = (state != IDLE);
    pop          = (fifo_count != 4'd0) && ((state == IDLE) || (state == STOP && bit_tc));
    data_next    = pop ? mem[rd_ptr] : frame_data;
    bit_idx_next = bit_idx;
    if (pop)                        bit_idx_next = 3'd0;
    else if (state == DATA && bit_tc) bit_idx_next = bit_idx + 3'd1;
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_next[bit_idx_next];
      PARITY:  tx_next = ^frame_data;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx         <= 1'b1;
      bit_cnt    <= 8'd0;
      bit_idx    <= 3'd0;
      frame_data <= 8'd0;
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      fifo_count <= 4'd0;
      overflow   <= 1'b0;
    end else begin
      tx         <= tx_next;
      bit_idx    <= bit_idx_next;
      frame_data <= data_next;
      if (state_next == IDLE)          bit_cnt <= 8'd0;
      else if (state == IDLE || bit_tc) bit_cnt <= BIT_LOAD;
      else                             bit_cnt <= bit_cnt - 8'd1;
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 4'd1;
        2'b01:   fifo_count <= fifo_count - 4'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (sample_valid && !sample_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= sample_in;
  end

endmodule

// File: tb/tb_telemetry_tx.sv
// Bench for telemetry_tx: a queue-plus-frame-position model predicts
// {tx, busy, fifo_count, overflow, sample_ready} every cycle.
module tb_telemetry_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready, tx, busy, overflow;
  logic [3:0] fifo_count;

  telemetry_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_vec, n_bad;
  logic [7:0]  obs;

  // model: pending samples, byte in flight, cycle position inside its frame (-1 = idle)
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_pos;
  logic       m_ovf;

  function automatic logic m_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (b == 9) return ^m_cur;
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_vec();
    return {m_tx(), (m_pos >= 0), 4'(m_q.size()), m_ovf, (m_q.size() < 8)};
  endfunction

  task automatic m_edge();
    int  pre;
    logic rdy;
    if (reset) begin
      m_q.delete();
      m_pos = -1;
      m_ovf = 1'b0;
      return;
    end
    pre = m_q.size();
    rdy = (pre < 8);
    if (m_pos < 0 || m_pos == FRAME - 1) begin
      if (pre > 0) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
      end else m_pos = -1;
    end else m_pos++;
    if (sample_valid) begin
      if (rdy) m_q.push_back(sample_in);
      else     m_ovf = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_valid = 1'b1; sample_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin reset = 1'b0; sample_valid = 1'b0; end
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL reset cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
    end
    n_vec++;
    if (fifo_count !== 4'd0 || tx !== 1'b1) begin
      n_bad++; $display("FAIL reset_no_write count=%0d tx=%b exp count=0 tx=1", fifo_count, tx);
    end
  endtask

  task automatic test_single();
    int busy_cycles = 0, rises = 0;
    logic prev = 1'b0;
    sample_valid = 1'b1; sample_in = 8'hA5;
    for (int i = 0; i < 52; i++) begin
      tick();
      sample_valid = 1'b0;
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL single cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
      if (busy) busy_cycles++;
      if (busy && !prev) rises++;
      prev = busy;
    end
    n_vec++;
    if (busy_cycles != 44 || rises != 1 || fifo_count !== 4'd0) begin
      n_bad++;
      $display("FAIL single_len busy_cycles=%0d rises=%0d count=%0d exp 44 1 0", busy_cycles, rises, fifo_count);
    end
  endtask

  task automatic test_parity();
    logic [7:0] pats [2];
    pats[0] = 8'h07; pats[1] = 8'h00;
    for (int p = 0; p < 2; p++) begin
      int k = -1;
      logic seen = 1'b0;
      logic want = ^pats[p];
      sample_valid = 1'b1; sample_in = pats[p];
      for (int i = 0; i < 52; i++) begin
        tick();
        sample_valid = 1'b0;
        obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
        if (obs !== m_vec()) begin
          n_bad++; $display("FAIL parity cyc=%0d obs=%b exp=%b", i, obs, m_vec());
        end
        if (k >= 0) k++;
        else if (busy) k = 0;
        if (k == 37) begin
          seen = 1'b1; n_vec++;
          if (tx !== want) begin
            n_bad++; $display("FAIL parity_bit data=%h tx=%b exp=%b", pats[p], tx, want);
          end
        end
      end
      n_vec++;
      if (!seen) begin n_bad++; $display("FAIL parity_frame data=%h frame not observed", pats[p]); end
    end
  endtask

  task automatic test_overflow();
    int rises = 0, falls = 0;
    logic prev;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1; sample_in = 8'($urandom);
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL ovf_fill cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
    end
    sample_valid = 1'b0;
    n_vec++;
    if (fifo_count !== 4'd8 || sample_ready !== 1'b0 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_full count=%0d ready=%b ovf=%b exp 8 0 1", fifo_count, sample_ready, overflow);
    end
    prev = busy;
    for (int i = 0; i < 9 * FRAME + 20; i++) begin
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL ovf_drain cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
      if (busy && !prev) rises++;
      if (!busy && prev) falls++;
      prev = busy;
    end
    n_vec++;
    if (rises != 0 || falls != 1) begin
      n_bad++; $display("FAIL ovf_gap rises=%0d falls=%0d exp 0 1", rises, falls);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
    if (obs !== m_vec()) begin
      n_bad++; $display("FAIL ovf_clear obs=%b exp=%b", obs, m_vec());
    end
  endtask

  task automatic test_simultaneous();
    logic hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample_in = 8'($urandom);
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL simul_load cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_pos == FRAME - 1) begin hit = 1'b1; break; end
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL simul_wait cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
    end
    sample_valid = hit; sample_in = 8'($urandom);
    tick();
    sample_valid = 1'b0;
    n_vec++;
    if (fifo_count !== 4'd3 || busy !== 1'b1 || tx !== 1'b0) begin
      n_bad++; $display("FAIL simul_count count=%0d busy=%b tx=%b exp 3 1 0", fifo_count, busy, tx);
    end
    for (int i = 0; i < 4 * FRAME + 10; i++) begin
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL simul_drain cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int rises = 0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; sample_in = 8'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (m_pos == 4 * CPB + 1) break;
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL rmid_run cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
    end
    n_vec++;
    if (fifo_count !== 4'd2 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rmid_pre count=%0d busy=%b exp 2 1", fifo_count, busy);
    end
    reset = 1'b1; sample_valid = 1'b1;
    tick();
    reset = 1'b0; sample_valid = 1'b0;
    n_vec++;
    if ({tx, busy, fifo_count, overflow} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL rmid_post tx=%b busy=%b count=%0d ovf=%b exp 1 0 0 0", tx, busy, fifo_count, overflow);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL rmid_quiet cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
      if (busy) rises++;
    end
    n_vec++;
    if (rises != 0) begin n_bad++; $display("FAIL rmid_frames busy_cycles=%0d exp 0", rises); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900 + 9 * FRAME; i++) begin
      if (i < 900) begin
        sample_valid = ($urandom_range(0, 9) < 2);
        sample_in    = 8'($urandom);
        reset        = ($urandom_range(0, 399) == 0);
      end else begin
        sample_valid = 1'b0; reset = 1'b0;
      end
      tick();
      obs = {tx, busy, fifo_count, overflow, sample_ready}; n_vec++;
      if (obs !== m_vec()) begin
        n_bad++; $display("FAIL random cyc=%0d obs=%b exp=%b", i, obs, m_vec());
      end
    end
    reset = 1'b0; sample_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    m_pos = -1; m_ovf = 1'b0; m_cur = 8'd0;
    reset = 1'b1; sample_valid = 1'b0; sample_in = 8'd0;
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
